// File: rtl/lsu_scratchpad.sv
// Four-bank FIFO scratchpad serving LSU ports 1-4, with an optional off-chip access port.
// Off-chip access is built only when LSU_SCRATCHPAD_OFFCHIP_EN is defined.
module lsu_scratchpad #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pe1,
  input  logic [31:0] pe2,
  input  logic [31:0] pe3,
  input  logic [31:0] pe4,
  input  logic [17:0] inst_in,
  output logic [31:0] lsu_to_pe,
  input  logic [42:0] lsu2_bus,
  input  logic [42:0] lsu3_bus,
  input  logic [42:0] lsu4_bus,
  input  logic [43:0] off_chip_bus,
  output logic [32:0] read_out2_bus,
  output logic [32:0] read_out3_bus,
  output logic [32:0] read_out4_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   w_pe_data;
  logic [42:0]   w_lsu1_req;
  logic [3:0]    w_en;
  logic [3:0]    w_wr;
  logic [31:0]   w_dat [4];
  logic [3:0]    w_push;
  logic [3:0]    w_pop;
  logic          w_unused;

  logic [AW-1:0] r_wptr  [4];
  logic [AW-1:0] r_rptr  [4];
  logic [CW-1:0] r_count [4];
  logic [31:0]   r_mem   [4][DEPTH];
  logic [3:0]    r_rd_valid;
  logic [31:0]   r_rd_data [4];
  logic [31:0]   r_lsu_to_pe;

  always_comb begin
    w_pe_data = pe1;
    case (inst_in[7:6])
      2'd1:    w_pe_data = pe2;
      2'd2:    w_pe_data = pe3;
      2'd3:    w_pe_data = pe4;
      default: w_pe_data = pe1;
    endcase
  end

  // LSU port 1 request, laid out exactly like the port 2-4 buses.
  assign w_lsu1_req = {1'b0, inst_in[9], inst_in[8], inst_in[17:10], w_pe_data};

  always_comb begin
    w_en   = {lsu4_bus[41], lsu3_bus[41], lsu2_bus[41], w_lsu1_req[41]};
    w_wr   = {lsu4_bus[40], lsu3_bus[40], lsu2_bus[40], w_lsu1_req[40]};
    w_dat[0] = w_lsu1_req[31:0];
    w_dat[1] = lsu2_bus[31:0];
    w_dat[2] = lsu3_bus[31:0];
    w_dat[3] = lsu4_bus[31:0];
`ifdef LSU_SCRATCHPAD_OFFCHIP_EN
    // Off-chip overrides the targeted bank's LSU request for this cycle.
    if (off_chip_bus[43]) begin
      w_en[off_chip_bus[42:41]]  = 1'b1;
      w_wr[off_chip_bus[42:41]]  = off_chip_bus[40];
      w_dat[off_chip_bus[42:41]] = off_chip_bus[31:0];
    end
`endif
    for (int b = 0; b < 4; b++) begin
      w_push[b] = w_en[b] & w_wr[b] & (r_count[b] != FULL);
      w_pop[b]  = w_en[b] & ~w_wr[b] & (r_count[b] != '0);
    end
  end

  // Addresses and reserved bits travel on the buses but never steer a bank.
  assign w_unused = ^{inst_in[5:0], w_lsu1_req[42], w_lsu1_req[39:32],
                      lsu2_bus[42], lsu2_bus[39:32], lsu3_bus[42], lsu3_bus[39:32],
                      lsu4_bus[42], lsu4_bus[39:32], off_chip_bus};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        r_wptr[b]    <= '0;
        r_rptr[b]    <= '0;
        r_count[b]   <= '0;
        r_rd_data[b] <= '0;
      end
      r_rd_valid  <= '0;
      r_lsu_to_pe <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_push[b]) r_wptr[b] <= r_wptr[b] + 1'b1;
        if (w_pop[b]) begin
          r_rptr[b]    <= r_rptr[b] + 1'b1;
          r_rd_data[b] <= r_mem[b][r_rptr[b]];
        end
        r_count[b] <= r_count[b] + {{AW{1'b0}}, w_push[b]} - {{AW{1'b0}}, w_pop[b]};
      end
      r_rd_valid <= w_pop;
      if (r_rd_valid[0]) r_lsu_to_pe <= r_rd_data[0];
    end
  end

  // Storage is not reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_push[b]) r_mem[b][r_wptr[b]] <= w_dat[b];
    end
  end

  assign lsu_to_pe     = r_lsu_to_pe;
  assign read_out2_bus = {r_rd_valid[1], r_rd_data[1]};
  assign read_out3_bus = {r_rd_valid[2], r_rd_data[2]};
  assign read_out4_bus = {r_rd_valid[3], r_rd_data[3]};

endmodule

// File: tb/tb_lsu_scratchpad.sv
// Bench for lsu_scratchpad: directed boundary cases, then randomized traffic against a queue model.
module tb_lsu_scratchpad;

  localparam int DEPTH = 16;
  localparam logic [17:0] INST_WR1 = 18'b000100001100000000;
  localparam logic [17:0] INST_RD1 = 18'b000100001000000000;

  logic        clk;
  logic        rst;
  logic [31:0] pe1, pe2, pe3, pe4;
  logic [17:0] inst_in;
  logic [31:0] lsu_to_pe;
  logic [42:0] lsu2_bus, lsu3_bus, lsu4_bus;
  logic [43:0] off_chip_bus;
  logic [32:0] read_out2_bus, read_out3_bus, read_out4_bus;

  int n_checks;
  int n_fail;

  logic [31:0] q [4][$];
  logic        m_valid [4];
  logic [31:0] m_data  [4];
  logic [31:0] m_lsu;

  lsu_scratchpad #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pe1(pe1), .pe2(pe2), .pe3(pe3), .pe4(pe4),
    .inst_in(inst_in), .lsu_to_pe(lsu_to_pe),
    .lsu2_bus(lsu2_bus), .lsu3_bus(lsu3_bus), .lsu4_bus(lsu4_bus),
    .off_chip_bus(off_chip_bus),
    .read_out2_bus(read_out2_bus), .read_out3_bus(read_out3_bus), .read_out4_bus(read_out4_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      q[b].delete();
      m_valid[b] = 1'b0;
      m_data[b]  = '0;
    end
    m_lsu = '0;
  endtask

  // One rising edge of the reference: queues per bank, read result visible next cycle.
  task automatic model_step();
    logic        en  [4];
    logic        wr  [4];
    logic [31:0] dat [4];
    logic [31:0] nxt_lsu;
    int t;
    nxt_lsu = m_valid[0] ? m_data[0] : m_lsu;
    en[0] = inst_in[9];   wr[0] = inst_in[8];
    case (inst_in[7:6])
      2'd0: dat[0] = pe1;
      2'd1: dat[0] = pe2;
      2'd2: dat[0] = pe3;
      default: dat[0] = pe4;
    endcase
    en[1] = lsu2_bus[41]; wr[1] = lsu2_bus[40]; dat[1] = lsu2_bus[31:0];
    en[2] = lsu3_bus[41]; wr[2] = lsu3_bus[40]; dat[2] = lsu3_bus[31:0];
    en[3] = lsu4_bus[41]; wr[3] = lsu4_bus[40]; dat[3] = lsu4_bus[31:0];
`ifdef LSU_SCRATCHPAD_OFFCHIP_EN
    if (off_chip_bus[43]) begin
      t = int'(off_chip_bus[42:41]);
      en[t] = 1'b1; wr[t] = off_chip_bus[40]; dat[t] = off_chip_bus[31:0];
    end
`endif
    for (int b = 0; b < 4; b++) begin
      m_valid[b] = 1'b0;
      if (en[b] && wr[b]) begin
        if (q[b].size() < DEPTH) q[b].push_back(dat[b]);
      end else if (en[b] && q[b].size() > 0) begin
        m_valid[b] = 1'b1;
        m_data[b]  = q[b].pop_front();
      end
    end
    m_lsu = nxt_lsu;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".ro2"}, 64'(read_out2_bus), 64'({m_valid[1], m_data[1]}));
    check_eq({tag, ".ro3"}, 64'(read_out3_bus), 64'({m_valid[2], m_data[2]}));
    check_eq({tag, ".ro4"}, 64'(read_out4_bus), 64'({m_valid[3], m_data[3]}));
    check_eq({tag, ".lsu"}, 64'(lsu_to_pe), 64'(m_lsu));
  endtask

  task automatic tick(input string tag);
    if (!rst) model_reset();
    else      model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    inst_in = '0; lsu2_bus = '0; lsu3_bus = '0; lsu4_bus = '0; off_chip_bus = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    tick("rst");
    rst = 1'b1;
  endtask

  logic [31:0] wr_vals [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    pe1 = '0; pe2 = '0; pe3 = '0; pe4 = '0;
    set_idle();
    model_reset();
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    rst = 1'b1;

    // Bank 1 order and two-cycle latency.
    wr_vals = '{32'd1, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    for (int i = 0; i < 6; i++) begin
      inst_in = INST_WR1; pe1 = wr_vals[i];
      tick("b1_wr");
    end
    for (int i = 0; i < 5; i++) begin
      inst_in = (i < 4) ? INST_RD1 : 18'd0;
      tick("b1_rd");
      if (i >= 1) check_eq("b1_order", 64'(lsu_to_pe), 64'(wr_vals[i-1]));
    end

    // Full and empty boundaries, mirrored on bank 1 and bank 2.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      inst_in = INST_WR1; pe1 = 32'(i);
      lsu2_bus = {1'b0, 1'b1, 1'b1, 8'h00, 32'(i)};
      tick("full_wr");
    end
    for (int i = 1; i <= 17; i++) begin
      inst_in = INST_RD1;
      lsu2_bus = {1'b0, 1'b1, 1'b0, 8'h00, 32'h0};
      tick("empty_rd");
      if (i <= 16) check_eq("full_ro2", 64'(read_out2_bus), 64'({1'b1, 32'(i)}));
      else         check_eq("empty_ro2", 64'(read_out2_bus), 64'({1'b0, 32'd16}));
    end
    set_idle();
    tick("drain");
    tick("drain");
    check_eq("empty_lsu_hold", 64'(lsu_to_pe), 64'd16);

    // PE select.
    do_reset();
    pe1 = 32'd3; pe2 = 32'd4; pe3 = 32'd5; pe4 = 32'd6;
    inst_in = {8'h00, 1'b1, 1'b1, 2'd2, 6'd0};
    tick("pesel_wr");
    inst_in = INST_RD1;
    tick("pesel_rd");
    set_idle();
    tick("pesel_wait");
    check_eq("pesel_lsu", 64'(lsu_to_pe), 64'd5);

    // Off-chip priority on bank 2.
    do_reset();
    off_chip_bus = {1'b1, 2'd1, 1'b1, 8'h00, 32'hAA};
    lsu2_bus     = {1'b0, 1'b1, 1'b1, 8'h00, 32'h55};
    tick("offc_wr");
    off_chip_bus = '0;
    lsu2_bus     = {1'b0, 1'b1, 1'b0, 8'h00, 32'h0};
    tick("offc_rd1");
`ifdef LSU_SCRATCHPAD_OFFCHIP_EN
    check_eq("offc_first", 64'(read_out2_bus), 64'({1'b1, 32'hAA}));
`else
    check_eq("offc_first", 64'(read_out2_bus), 64'({1'b1, 32'h55}));
`endif
    tick("offc_rd2");
    check_eq("offc_second_valid", 64'(read_out2_bus[32]), 64'd0);

    // Reset mid-operation, with writes presented while reset is low.
    set_idle();
    for (int i = 0; i < 3; i++) begin
      inst_in = INST_WR1; pe1 = 32'(100 + i);
      lsu2_bus = {1'b0, 1'b1, 1'b1, 8'h00, 32'(200 + i)};
      tick("mid_wr");
    end
    rst = 1'b0;
    #1;
    model_reset();
    check_all("mid_async");
    tick("mid_rst");
    rst = 1'b1;
    inst_in = INST_RD1;
    lsu2_bus = {1'b0, 1'b1, 1'b0, 8'h00, 32'h0};
    tick("mid_rd");
    check_eq("mid_ro2_valid", 64'(read_out2_bus[32]), 64'd0);
    set_idle();
    tick("mid_wait");
    check_eq("mid_lsu", 64'(lsu_to_pe), 64'd0);

    // Randomized traffic; write bias swings so banks visit both full and empty.
    for (int i = 0; i < 1500; i++) begin
      int wbias;
      wbias = ((i / 100) % 2 == 0) ? 75 : 25;
      pe1 = $urandom; pe2 = $urandom; pe3 = $urandom; pe4 = $urandom;
      inst_in = 18'($urandom);
      inst_in[9] = ($urandom_range(99) < 80);
      inst_in[8] = ($urandom_range(99) < wbias);
      lsu2_bus = {11'($urandom), $urandom};
      lsu2_bus[41] = ($urandom_range(99) < 80);
      lsu2_bus[40] = ($urandom_range(99) < wbias);
      lsu3_bus = {11'($urandom), $urandom};
      lsu3_bus[40] = ($urandom_range(99) < wbias);
      lsu4_bus = {11'($urandom), $urandom};
      lsu4_bus[40] = ($urandom_range(99) < wbias);
      off_chip_bus = {12'($urandom), $urandom};
      off_chip_bus[43] = ($urandom_range(99) < 25);
      rst = ($urandom_range(299) != 0);
      tick("rand");
      rst = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
